alu_op_dispatcher: RTL and testbench

- Upstream issue stage for Sequential_ALU.
- Accepts operation requests (opcode, in1, in2) through a valid/ready port and buffers them in a small FIFO.
- Replays the ALU's reset → gap → start → wait-done protocol for each job, then presents each result on a valid/ready response port.
- Lets the rest of the design stream ALU jobs back-to-back without hand-sequencing the ALU.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_req_fifo.sv | 55 +++++
 rtl/alu_op_dispatcher.sv | 169 ++++++++++++++++
 tb/tb_alu_op_dispatcher.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the Sequential_ALU op dispatcher: opcodes, FSM state
// encoding and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [DEFAULT_WIDTH-1:0] OP_ADD = 4'd0;
  localparam logic [DEFAULT_WIDTH-1:0] OP_SUB = 4'd1;
  localparam logic [DEFAULT_WIDTH-1:0] OP_MUL = 4'd2;
  localparam logic [DEFAULT_WIDTH-1:0] OP_DIV = 4'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLR   = 3'd1;
  localparam state_t ST_SETUP = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the dispatcher, holding packed {opcode, in1, in2} words.
// No bypass; pointers wrap modulo DEPTH, which must be a power of two.
module alu_req_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/alu_op_dispatcher.sv
// Issue stage for Sequential_ALU: queues requests, replays clear/gap/start/wait
// per job and holds each result. Define ALU_TIMEOUT_EN for the WAIT watchdog.
module alu_op_dispatcher
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH-1:0]           req_opcode,
  input  logic [WIDTH-1:0]           req_in1,
  input  logic [WIDTH-1:0]           req_in2,
  output logic                       alu_reset,
  output logic                       alu_start,
  output logic [WIDTH-1:0]           alu_opcode,
  output logic [WIDTH-1:0]           alu_in1,
  output logic [WIDTH-1:0]           alu_in2,
  input  logic                       alu_done,
  input  logic [WIDTH-1:0]           alu_high,
  input  logic [WIDTH-1:0]           alu_low,
  input  logic                       alu_flag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_opcode,
  output logic [WIDTH-1:0]           rsp_high,
  output logic [WIDTH-1:0]           rsp_low,
  output logic                       rsp_flag,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int DW = 3 * WIDTH;

  state_t           r_state;
  logic [WIDTH-1:0] r_job_op, r_job_in1, r_job_in2;
  logic             r_alu_reset, r_alu_start;
  logic             r_rsp_valid, r_rsp_flag, r_rsp_err;
  logic [WIDTH-1:0] r_rsp_op, r_rsp_high, r_rsp_low;
  logic [DW-1:0]    w_head;
  logic             w_full, w_empty, w_pop, w_slot_free, w_expired, w_load;

  alu_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst_n (reset),
    .i_push  (req_valid),
    .i_data  ({req_opcode, req_in1, req_in2}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  // Slot counts as free when the held response leaves on this same edge.
  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_load      = (r_state == ST_WAIT) && w_slot_free && (alu_done || w_expired);

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;

  // Counter saturates at expiry so a blocked error response waits without wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_tmo_cnt <= TW'(1);
    end else if (r_state == ST_WAIT && !w_expired) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  assign w_expired = (r_tmo_cnt >= TW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_job_op    <= '0;
      r_job_in1   <= '0;
      r_job_in2   <= '0;
      r_alu_reset <= 1'b1;
      r_alu_start <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_job_op    <= w_head[3*WIDTH-1:2*WIDTH];
            r_job_in1   <= w_head[2*WIDTH-1:WIDTH];
            r_job_in2   <= w_head[WIDTH-1:0];
            r_alu_reset <= 1'b1;
            r_state     <= ST_CLR;
          end else begin
            r_alu_reset <= 1'b0;
          end
        end
        ST_CLR: begin
          r_alu_reset <= 1'b0;
          r_state     <= ST_SETUP;
        end
        ST_SETUP: begin
          r_alu_start <= 1'b1;
          r_state     <= ST_START;
        end
        ST_START: begin
          r_alu_start <= 1'b0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_load) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= '0;
      r_rsp_high  <= '0;
      r_rsp_low   <= '0;
      r_rsp_flag  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_load) begin
      r_rsp_valid <= 1'b1;
      r_rsp_op    <= r_job_op;
      // A real done always wins over a simultaneous watchdog expiry.
      if (alu_done) begin
        r_rsp_high <= alu_high;
        r_rsp_low  <= alu_low;
        r_rsp_flag <= alu_flag;
        r_rsp_err  <= 1'b0;
      end else begin
        r_rsp_high <= '0;
        r_rsp_low  <= '0;
        r_rsp_flag <= 1'b0;
        r_rsp_err  <= 1'b1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready  = !w_full;
  assign alu_reset  = r_alu_reset;
  assign alu_start  = r_alu_start;
  assign alu_opcode = r_job_op;
  assign alu_in1    = r_job_in1;
  assign alu_in2    = r_job_in2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_opcode = r_rsp_op;
  assign rsp_high   = r_rsp_high;
  assign rsp_low    = r_rsp_low;
  assign rsp_flag   = r_rsp_flag;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher with a behavioural Sequential_ALU attached.
// Define ALU_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_alu_op_dispatcher;
  import alu_pkg::*;

  localparam int W       = 4;
  localparam int D       = 4;
  localparam int TMO     = 8;
  localparam int ALU_LAT = 3;

  typedef struct packed {
    logic [W-1:0] op;
    logic [W-1:0] high;
    logic [W-1:0] low;
    logic         flag;
    logic         err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_opcode = '0, req_in1 = '0, req_in2 = '0;
  logic         alu_reset, alu_start;
  logic [W-1:0] alu_opcode, alu_in1, alu_in2;
  logic         alu_done = 1'b0, alu_flag = 1'b0;
  logic [W-1:0] alu_high = '0, alu_low = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_opcode, rsp_high, rsp_low;
  logic         rsp_flag, rsp_err;
  logic [2:0]   count;
  logic         busy;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   alu_cnt = 0;
  bit   hang = 1'b0;
  rsp_t rq[$];

  alu_op_dispatcher #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_in1(req_in1), .req_in2(req_in2),
    .alu_reset(alu_reset), .alu_start(alu_start),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_done(alu_done), .alu_high(alu_high), .alu_low(alu_low), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_opcode(rsp_opcode), .rsp_high(rsp_high), .rsp_low(rsp_low),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] alu_eval(input logic [W-1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [4:0] s;
    logic [7:0] p;
    s = '0;
    p = '0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; return {s[4], 4'h0, s[3:0]}; end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; return {(a < b), 4'h0, s[3:0]}; end
      OP_MUL: begin p = {4'h0, a} * {4'h0, b}; return {1'b0, p[7:4], p[3:0]}; end
      OP_DIV: begin
        if (b == 0) return {1'b1, 4'hF, 4'hF};
        return {1'b0, a % b, a / b};
      end
      default: return 9'h0;
    endcase
  endfunction

  // Behavioural ALU: cleared by alu_reset, done held high ALU_LAT edges after start.
  always @(posedge clk) begin
    if (alu_reset) begin
      alu_done <= 1'b0; alu_high <= '0; alu_low <= '0; alu_flag <= 1'b0; alu_cnt <= 0;
    end else if (alu_start) begin
      alu_cnt <= ALU_LAT;
    end else if (alu_cnt > 1) begin
      alu_cnt <= alu_cnt - 1;
    end else if (alu_cnt == 1) begin
      alu_cnt <= 0;
      if (!hang) begin
        alu_done <= 1'b1;
        {alu_flag, alu_high, alu_low} <= alu_eval(alu_opcode, alu_in1, alu_in2);
      end
    end
  end

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) rq.push_back({rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1; req_opcode = op; req_in1 = a; req_in2 = b;
    for (int k = 0; k < 200; k++) begin
      if (req_ready) begin
        tick();
        req_valid = 1'b0;
        return;
      end
      tick();
    end
    req_valid = 1'b0;
    n_vec++; n_err++;
    $display("FAIL push_accept: req_ready never rose, required 1");
  endtask

  task automatic wait_rsps(input int n, input int budget);
    for (int k = 0; k < budget && rq.size() < n; k++) tick();
    n_vec++;
    if (rq.size() < n) begin
      n_err++;
      $display("FAIL rsp_wait: got %0d responses, required %0d", rq.size(), n);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_vec++;
    if ({alu_reset, alu_start, rsp_valid, busy, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_ctrl: rst/start/valid/busy/count=%b/%b/%b/%b/%0d required 1/0/0/0/0",
               alu_reset, alu_start, rsp_valid, busy, count);
    end
    n_vec++;
    if ({alu_opcode, alu_in1, alu_in2, rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err} !== '0) begin
      n_err++;
      $display("FAIL reset_data: job %h%h%h rsp %h%h%h%b%b required all zero",
               alu_opcode, alu_in1, alu_in2, rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err);
    end
    reset = 1'b1;
    tick();
    n_vec++;
    if (alu_reset !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: alu_reset=%b req_ready=%b required 0/1", alu_reset, req_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    int n0;
    rq.delete();
    rsp_ready = 1'b1;
    push(OP_ADD, 4'd7, 4'd9);
    n0 = cyc;
    n_vec++;
    if (count !== 3'd1 || alu_reset !== 1'b0) begin
      n_err++;
      $display("FAIL single_accept: count=%0d alu_reset=%b required 1/0", count, alu_reset);
    end
    tick();
    n_vec++;
    if ({alu_reset, busy, count, alu_opcode, alu_in1, alu_in2} !== {1'b1, 1'b1, 3'd0, 4'd0, 4'd7, 4'd9}) begin
      n_err++;
      $display("FAIL single_clr: rst=%b busy=%b count=%0d job=%h/%h/%h required 1/1/0/0/7/9",
               alu_reset, busy, count, alu_opcode, alu_in1, alu_in2);
    end
    tick();
    n_vec++;
    if (alu_reset !== 1'b0 || alu_start !== 1'b0) begin
      n_err++;
      $display("FAIL single_setup: rst=%b start=%b required 0/0", alu_reset, alu_start);
    end
    tick();
    n_vec++;
    if (alu_start !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: alu_start=%b required 1 at N+4", alu_start);
    end
    tick();
    n_vec++;
    if (alu_start !== 1'b0) begin
      n_err++;
      $display("FAIL single_start_pulse: alu_start=%b required 0", alu_start);
    end
    for (int k = 0; k < 50 && !rsp_valid; k++) tick();
    n_vec++;
    if (cyc - n0 !== 8) begin
      n_err++;
      $display("FAIL single_latency: rsp_valid after %0d edges, required 8", cyc - n0);
    end
    n_vec++;
    if ({rsp_valid, rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err} !== {1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL single_rsp: v=%b op=%h hi=%h lo=%h f=%b e=%b required 1/0/0/0/1/0",
               rsp_valid, rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rq.size() != 1) begin
      n_err++;
      $display("FAIL single_drain: v=%b busy=%b nrsp=%0d required 0/0/1", rsp_valid, busy, rq.size());
    end
    $display("single: ADD 7+9 checked");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops[4] = '{OP_MUL, OP_SUB, OP_DIV, OP_ADD};
    logic [W-1:0] as[4]  = '{4'd13, 4'd3, 4'd13, 4'd1};
    logic [W-1:0] bs[4]  = '{4'd11, 4'd5, 4'd4, 4'd1};
    rsp_t exp[4] = '{{4'd2, 4'h8, 4'hF, 1'b0, 1'b0}, {4'd1, 4'h0, 4'hE, 1'b1, 1'b0},
                     {4'd3, 4'h1, 4'h3, 1'b0, 1'b0}, {4'd0, 4'h0, 4'h2, 1'b0, 1'b0}};
    int maxc = 0;
    rq.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: req_ready=%b required 1", i, req_ready);
      end
      push(ops[i], as[i], bs[i]);
      if (int'(count) > maxc) maxc = int'(count);
    end
    n_vec++;
    if (maxc > 4) begin
      n_err++;
      $display("FAIL b2b_count_peak: peak=%0d required <=4", maxc);
    end
    wait_rsps(4, 200);
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      n_vec++;
      if (rq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_rsp[%0d]: got %h required %h", i, rq[i], exp[i]);
      end
    end
    $display("back_to_back: 4 jobs checked, count peak %0d", maxc);
  endtask

  task automatic test_full_stall();
    logic [W-1:0] ops[5] = '{OP_ADD, OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    logic [W-1:0] as[5]  = '{4'd2, 4'd15, 4'd10, 4'd15, 4'd9};
    logic [W-1:0] bs[5]  = '{4'd2, 4'd15, 4'd3, 4'd15, 4'd2};
    rsp_t exp[5] = '{{4'd0, 4'h0, 4'h4, 1'b0, 1'b0}, {4'd0, 4'h0, 4'hE, 1'b1, 1'b0},
                     {4'd1, 4'h0, 4'h7, 1'b0, 1'b0}, {4'd2, 4'hE, 4'h1, 1'b0, 1'b0},
                     {4'd3, 4'h1, 4'h4, 1'b0, 1'b0}};
    rq.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(ops[i], as[i], bs[i]);
    n_vec++;
    if (count !== 3'd4 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_full: count=%0d req_ready=%b required 4/0", count, req_ready);
    end
    req_valid = 1'b1; req_opcode = OP_ADD; req_in1 = 4'd5; req_in2 = 4'd6;
    tick(); tick();
    n_vec++;
    if (count !== 3'd4 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_holdoff: count=%0d req_ready=%b required 4/0", count, req_ready);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    n_vec++;
    if ({rsp_valid, busy, count, req_ready} !== {1'b1, 1'b1, 3'd3, 1'b1} || rq.size() != 0) begin
      n_err++;
      $display("FAIL stall_parked: v=%b busy=%b count=%0d rdy=%b nrsp=%0d required 1/1/3/1/0",
               rsp_valid, busy, count, req_ready, rq.size());
    end
    rsp_ready = 1'b1;
    wait_rsps(5, 300);
    for (int k = 0; k < 30; k++) tick();
    n_vec++;
    if (rq.size() != 5) begin
      n_err++;
      $display("FAIL stall_count: %0d responses, required 5", rq.size());
    end
    for (int i = 0; i < 5 && i < rq.size(); i++) begin
      n_vec++;
      if (rq[i] !== exp[i]) begin
        n_err++;
        $display("FAIL stall_rsp[%0d]: got %h required %h", i, rq[i], exp[i]);
      end
    end
    $display("full_stall: 5 jobs checked, extra request held off");
  endtask

  task automatic test_rsp_hold();
    rsp_t exp_a = {4'd1, 4'h0, 4'h7, 1'b0, 1'b0};
    rsp_t exp_b = {4'd2, 4'h0, 4'hF, 1'b0, 1'b0};
    rq.delete();
    rsp_ready = 1'b0;
    push(OP_SUB, 4'd9, 4'd2);
    push(OP_MUL, 4'd3, 4'd5);
    for (int k = 0; k < 50 && !rsp_valid; k++) tick();
    for (int k = 0; k < 20; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || {rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err} !== exp_a) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: v=%b data=%h required 1/%h", k, rsp_valid,
                 {rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err}, exp_a);
      end
      tick();
    end
    n_vec++;
    if (busy !== 1'b1 || count !== 3'd0) begin
      n_err++;
      $display("FAIL hold_parked: busy=%b count=%0d required 1/0", busy, count);
    end
    rsp_ready = 1'b1;
    tick();
    n_vec++;
    if (rsp_valid !== 1'b1 || {rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err} !== exp_b) begin
      n_err++;
      $display("FAIL hold_next: v=%b data=%h required 1/%h", rsp_valid,
               {rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err}, exp_b);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0 || rq.size() != 2) begin
      n_err++;
      $display("FAIL hold_drain: v=%b nrsp=%0d required 0/2", rsp_valid, rq.size());
    end else begin
      n_vec++;
      if (rq[0] !== exp_a || rq[1] !== exp_b) begin
        n_err++;
        $display("FAIL hold_order: got %h,%h required %h,%h", rq[0], rq[1], exp_a, exp_b);
      end
    end
    $display("rsp_hold: 20-cycle hold checked");
  endtask

  task automatic test_reset_mid();
    rq.delete();
    rsp_ready = 1'b1;
    push(OP_DIV, 4'd8, 4'd2);
    push(OP_ADD, 4'd1, 4'd2);
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({alu_reset, alu_start, busy, rsp_valid, count, req_ready} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_ctrl: rst/start/busy/v/count/rdy=%b/%b/%b/%b/%0d/%b required 1/0/0/0/0/1",
               alu_reset, alu_start, busy, rsp_valid, count, req_ready);
    end
    n_vec++;
    if ({alu_opcode, alu_in1, alu_in2} !== '0) begin
      n_err++;
      $display("FAIL midrst_job: job=%h/%h/%h required 0/0/0", alu_opcode, alu_in1, alu_in2);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    n_vec++;
    if (rq.size() != 0 || rsp_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_quiet: nrsp=%0d v=%b busy=%b count=%0d required 0/0/0/0",
               rq.size(), rsp_valid, busy, count);
    end
    $display("reset_mid: job discarded");
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    int ts;
    rsp_t exp_e = {4'd0, 4'h0, 4'h0, 1'b0, 1'b1};
    rsp_t exp_n = {4'd1, 4'h0, 4'h7, 1'b0, 1'b0};
    rq.delete();
    rsp_ready = 1'b1;
    hang = 1'b1;
    push(OP_ADD, 4'd2, 4'd3);
    push(OP_SUB, 4'd8, 4'd1);
    for (int k = 0; k < 50 && !alu_start; k++) tick();
    ts = cyc;
    for (int k = 0; k < 100 && !rsp_valid; k++) tick();
    n_vec++;
    if (cyc - ts !== TMO) begin
      n_err++;
      $display("FAIL tmo_latency: error rsp %0d cycles after start, required %0d", cyc - ts, TMO);
    end
    n_vec++;
    if (rsp_valid !== 1'b1 || {rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err} !== exp_e) begin
      n_err++;
      $display("FAIL tmo_rsp: v=%b data=%h required 1/%h", rsp_valid,
               {rsp_opcode, rsp_high, rsp_low, rsp_flag, rsp_err}, exp_e);
    end
    hang = 1'b0;
    wait_rsps(2, 200);
    if (rq.size() >= 2) begin
      n_vec++;
      if (rq[1] !== exp_n) begin
        n_err++;
        $display("FAIL tmo_next: got %h required %h", rq[1], exp_n);
      end
    end
    $display("timeout: error response and recovery checked");
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_stall();
    test_rsp_hold();
    test_reset_mid();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
